// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and digit validation helper.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  // A nibble is a legal BCD digit when it lies in 0..9.
  function automatic logic bcd_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD counter: holds a digit and passes carry/borrow onward.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  bcd_digit_t load_digit,
  input  logic       step_in,
  input  logic       up,
  output bcd_digit_t digit,
  output logic       step_out
);

  // Ripple to the next decade when this digit rolls over on the current step.
  always_comb begin
    step_out = step_in && (up ? (digit == BCD_MAX) : (digit == BCD_MIN));
  end

  // Digit register: clear, then load, then a single up/down step with BCD roll-over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit <= BCD_MIN;
    end else if (clr) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= load_digit;
    end else if (step_in) begin
      if (up) begin
        digit <= (digit == BCD_MAX) ? BCD_MIN : bcd_digit_t'(digit + 4'd1);
      end else begin
        digit <= (digit == BCD_MIN) ? BCD_MAX : bcd_digit_t'(digit - 4'd1);
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, clear, terminal count
// and overflow / rejected-load pulses. Digit 0 is the least significant.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS    = 4,
  parameter bit WRAP_MODE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] count,
  output logic                tc,
  output logic                ovf,
  output logic                load_err
);

  logic [DIGITS:0] step;
  logic            load_vld;
  logic            all_nine;
  logic            all_zero;
  logic            cell_load;
  logic            step_unused;

  // Whole-value decode: load legality and the two boundary patterns of count.
  always_comb begin
    load_vld = 1'b1;
    all_nine = 1'b1;
    all_zero = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(load_val[4*i +: 4])) load_vld = 1'b0;
      if (count[4*i +: 4] != BCD_MAX)     all_nine = 1'b0;
      if (count[4*i +: 4] != BCD_MIN)     all_zero = 1'b0;
    end
  end

  // Terminal count and chain entry; saturate mode suppresses the step at the boundary,
  // and any load (accepted or rejected) swallows the count enable.
  always_comb begin
    tc        = up ? all_nine : all_zero;
    cell_load = load && load_vld;
    step[0]   = en && !clr && !load && !(tc && !WRAP_MODE);
  end

  // The final carry-out only matters as the wrap itself, which tc already flags.
  assign step_unused = step[DIGITS];

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .load       (cell_load),
      .load_digit (load_val[4*i +: 4]),
      .step_in    (step[i]),
      .up         (up),
      .digit      (count[4*i +: 4]),
      .step_out   (step[i+1])
    );
  end

  // One-cycle status pulses: boundary hit while enabled, or a load with a non-BCD digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (clr) begin
      ovf      <= 1'b0;
      load_err <= 1'b0;
    end else if (load) begin
      ovf      <= 1'b0;
      load_err <= !load_vld;
    end else begin
      ovf      <= en && tc;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter share stimulus;
// expected responses are queued by the driver and checked by a monitor.
module tb_bcd_updown_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;

  logic [15:0] count_w, count_s;
  logic        tc_w, tc_s, ovf_w, ovf_s, lerr_w, lerr_s;

  int cyc_cnt = 0;
  int n_vec = 0;
  int n_mis = 0;
  event sample_ev;

  typedef struct {
    int          cyc;
    int          dut;
    string       name;
    logic [15:0] cnt;
    logic        tc;
    logic        ovf;
    logic        le;
  } exp_t;

  exp_t q[$];

  bcd_updown_counter #(.DIGITS(4), .WRAP_MODE(1'b1)) dut_w (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count_w), .tc(tc_w), .ovf(ovf_w), .load_err(lerr_w)
  );

  bcd_updown_counter #(.DIGITS(4), .WRAP_MODE(1'b0)) dut_s (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(count_s), .tc(tc_s), .ovf(ovf_s), .load_err(lerr_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic logic tc_of(input logic u, input logic [15:0] c);
    return u ? (c == 16'h9999) : (c == 16'h0000);
  endfunction

  task automatic push(input string nm, input int cyc, input int dut, input logic u,
                      input logic [15:0] c, input logic o, input logic le);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.name = nm;
    e.cnt  = c;
    e.tc   = tc_of(u, c);
    e.ovf  = o;
    e.le   = le;
    q.push_back(e);
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input string nm, input logic c, input logic l, input logic [15:0] lv,
                      input logic e, input logic u,
                      input logic [15:0] wc, input logic wo,
                      input logic [15:0] sc, input logic so, input logic le);
    @(negedge clk);
    clr = c; load = l; load_val = lv; en = e; up = u;
    push(nm, cyc_cnt + 1, 0, u, wc, wo, le);
    push(nm, cyc_cnt + 1, 1, u, sc, so, le);
  endtask

  // Queue an expectation for the present moment and wake the monitor now.
  task automatic expect_now(input string nm, input logic [15:0] wc, input logic wo,
                            input logic [15:0] sc, input logic so, input logic le);
    push(nm, cyc_cnt, 0, up, wc, wo, le);
    push(nm, cyc_cnt, 1, up, sc, so, le);
    -> sample_ev;
  endtask

  // Monitor: after each edge (or an explicit mid-cycle request) retire due expectations.
  initial begin
    exp_t        e;
    logic [15:0] ac;
    logic        at, ao, al;
    forever begin
      @(posedge clk or sample_ev);
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
        e = q.pop_front();
        if (e.dut == 0) begin
          ac = count_w; at = tc_w; ao = ovf_w; al = lerr_w;
        end else begin
          ac = count_s; at = tc_s; ao = ovf_s; al = lerr_s;
        end
        n_vec++;
        if ({ac, at, ao, al} !== {e.cnt, e.tc, e.ovf, e.le}) begin
          n_mis++;
          $display("FAIL %s %s: got count=%h tc=%b ovf=%b load_err=%b, want count=%h tc=%b ovf=%b load_err=%b",
                   e.name, (e.dut == 0) ? "wrap" : "sat", ac, at, ao, al,
                   e.cnt, e.tc, e.ovf, e.le);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    expect_now("reset", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    #2 rst = 1'b0;

    step("load_0347", 0, 1, 16'h0347, 0, 1, 16'h0347, 0, 16'h0347, 0, 0);

    // Asynchronous reset between edges, then the first enabled step after release.
    @(negedge clk);
    clr = 1'b0; load = 1'b0; load_val = 16'h0000; en = 1'b1; up = 1'b1;
    #2 rst = 1'b1;
    expect_now("async_rst", 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
    #2 rst = 1'b0;
    push("first_up", cyc_cnt + 1, 0, 1'b1, 16'h0001, 1'b0, 1'b0);
    push("first_up", cyc_cnt + 1, 1, 1'b1, 16'h0001, 1'b0, 1'b0);

    step("load_0999",    0, 1, 16'h0999, 0, 1, 16'h0999, 0, 16'h0999, 0, 0);
    step("cascade_up",   0, 0, 16'h0000, 1, 1, 16'h1000, 0, 16'h1000, 0, 0);
    step("cascade_down", 0, 0, 16'h0000, 1, 0, 16'h0999, 0, 16'h0999, 0, 0);
    step("load_9998",    0, 1, 16'h9998, 0, 1, 16'h9998, 0, 16'h9998, 0, 0);
    step("up_to_9999",   0, 0, 16'h0000, 1, 1, 16'h9999, 0, 16'h9999, 0, 0);
    step("boundary_up",  0, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'h9999, 1, 0);
    step("idle_bnd",     0, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h9999, 0, 0);
    step("load_9999",    0, 1, 16'h9999, 0, 1, 16'h9999, 0, 16'h9999, 0, 0);
    step("sat_up_1",     0, 0, 16'h0000, 1, 1, 16'h0000, 1, 16'h9999, 1, 0);
    step("sat_up_2",     0, 0, 16'h0000, 1, 1, 16'h0001, 0, 16'h9999, 1, 0);
    step("sat_up_3",     0, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h9999, 1, 0);
    step("sat_idle",     0, 0, 16'h0000, 0, 1, 16'h0002, 0, 16'h9999, 0, 0);
    step("clear",        1, 0, 16'h0000, 0, 1, 16'h0000, 0, 16'h0000, 0, 0);
    step("boundary_dn",  0, 0, 16'h0000, 1, 0, 16'h9999, 1, 16'h0000, 1, 0);
    step("idle_dn",      0, 0, 16'h0000, 0, 0, 16'h9999, 0, 16'h0000, 0, 0);
    step("load_12A4",    0, 1, 16'h12A4, 1, 1, 16'h9999, 0, 16'h0000, 0, 1);
    step("after_bad",    0, 0, 16'h0000, 0, 1, 16'h9999, 0, 16'h0000, 0, 0);
    step("load_1294",    0, 1, 16'h1294, 0, 1, 16'h1294, 0, 16'h1294, 0, 0);
    step("clr_load_en",  1, 1, 16'h5555, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);
    step("load_en",      0, 1, 16'h5555, 1, 1, 16'h5555, 0, 16'h5555, 0, 0);
    step("dir_flip",     0, 0, 16'h0000, 0, 0, 16'h5555, 0, 16'h5555, 0, 0);
    step("clr_bad_load", 1, 1, 16'hA000, 1, 1, 16'h0000, 0, 16'h0000, 0, 0);
    step("up_from_0",    0, 0, 16'h0000, 1, 1, 16'h0001, 0, 16'h0001, 0, 0);
    step("final_idle",   0, 0, 16'h0000, 0, 1, 16'h0001, 0, 16'h0001, 0, 0);

    repeat (3) @(negedge clk);
    n_vec++;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
